hub75_bcm_driver: RTL and testbench

//  Parametrised HUB75 LED-matrix scan driver with binary-coded-modulation (BCM) colour depth and a double-buffered frame store.

---
 rtl/hub75_bcm_driver_if.sv | 15 +
 rtl/hub75_bcm_driver.sv | 169 ++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_bcm_driver_if.sv
// Host-side port of the HUB75 BCM driver: pixel writes into the back bank
// and the front/back swap handshake.
interface hub75_bcm_driver_if #(
    parameter int ADR_W  = 10,
    parameter int DATA_W = 12
);
    logic              we;
    logic [ADR_W-1:0]  adr_in;
    logic [DATA_W-1:0] rgb_in;
    logic              swap_req;
    logic              swap_ack;

    modport master (output we, adr_in, rgb_in, swap_req, input swap_ack);
    modport slave  (input we, adr_in, rgb_in, swap_req, output swap_ack);
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scan driver with binary-coded modulation over a double-buffered
// frame store; the host fills the back bank while the front bank is scanned.
module hub75_bcm_driver #(
    parameter int COLS      = 32,
    parameter int ROWS      = 32,
    parameter int BITS      = 4,
    parameter int BLANK_CYC = 200,
    parameter int LATCH_CYC = 100,
    parameter int BASE_CYC  = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    hub75_bcm_driver_if.slave         host,
    output logic                      frame_start,
    output logic [2:0]                rgb_a,
    output logic [2:0]                rgb_b,
    output logic [$clog2(ROWS/2)-1:0] row_address,
    output logic                      outclk,
    output logic                      latch,
    output logic                      eo
);
    localparam int HALF   = ROWS / 2;
    localparam int NPIX   = ROWS * COLS;
    localparam int ADR_W  = $clog2(NPIX);
    localparam int DATA_W = 3 * BITS;
    localparam int RW     = $clog2(HALF);
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW     = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [2:0] {FETCH, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY} state_t;

    state_t            state;
    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic [PW-1:0]     plane;
    logic [31:0]       delay_cnt;
    logic              front;
    logic              swap_pend;
    logic              started;

    logic [DATA_W-1:0] mem [2][NPIX];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [ADR_W-1:0]  adr_a;
    logic [ADR_W-1:0]  adr_b;

    assign adr_a = ADR_W'(int'(row_cnt) * COLS + int'(col_cnt));
    assign adr_b = ADR_W'((int'(row_cnt) + HALF) * COLS + int'(col_cnt));

    // Writes always target the bank not being scanned, so a write in the swap
    // cycle still lands in the bank that is about to become the front.
    always_ff @(posedge clk) begin
        if (host.we)
            mem[~front][host.adr_in] <= host.rgb_in;
        rd_a <= mem[front][adr_a];
        rd_b <= mem[front][adr_b];
    end

    function automatic logic [2:0] plane_bits(input logic [DATA_W-1:0] d, input logic [PW-1:0] p);
        logic [2:0] bits;
        bits = 3'b000;
        for (int i = 0; i < BITS; i++)
            if (PW'(i) == p)
                bits = {d[2*BITS+i], d[BITS+i], d[i]};
        return bits;
    endfunction

    // Outputs are registered alongside the state, so each one reflects the
    // state being entered rather than the one being left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FETCH;
            col_cnt       <= '0;
            row_cnt       <= '0;
            plane         <= '0;
            delay_cnt     <= '0;
            front         <= 1'b0;
            swap_pend     <= 1'b0;
            started       <= 1'b0;
            rgb_a         <= '0;
            rgb_b         <= '0;
            row_address   <= '0;
            outclk        <= 1'b0;
            latch         <= 1'b0;
            eo            <= 1'b1;
            host.swap_ack <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            host.swap_ack <= 1'b0;
            frame_start   <= 1'b0;
            if (host.swap_req)
                swap_pend <= 1'b1;

            case (state)
                FETCH: begin
                    // The first FETCH after reset is held one extra cycle to emit frame_start.
                    if (!started) begin
                        started     <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        state <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    rgb_a  <= plane_bits(rd_a, plane);
                    rgb_b  <= plane_bits(rd_b, plane);
                    outclk <= 1'b1;
                    state  <= SHIFT_HI;
                end
                SHIFT_HI: begin
                    outclk <= 1'b0;
                    if (col_cnt == CW'(COLS - 1)) begin
                        col_cnt   <= '0;
                        delay_cnt <= 32'(BLANK_CYC - 1);
                        state     <= BLANK;
                    end else begin
                        col_cnt <= col_cnt + CW'(1);
                        state   <= FETCH;
                    end
                end
                BLANK: begin
                    if (delay_cnt == 32'd0) begin
                        latch       <= 1'b1;
                        row_address <= row_cnt;
                        delay_cnt   <= 32'(LATCH_CYC - 1);
                        state       <= LATCH;
                    end else begin
                        delay_cnt <= delay_cnt - 32'd1;
                    end
                end
                LATCH: begin
                    if (delay_cnt == 32'd0) begin
                        latch     <= 1'b0;
                        eo        <= 1'b0;
                        delay_cnt <= (32'(BASE_CYC) << plane) - 32'd1;
                        state     <= DISPLAY;
                    end else begin
                        delay_cnt <= delay_cnt - 32'd1;
                    end
                end
                DISPLAY: begin
                    if (delay_cnt == 32'd0) begin
                        eo    <= 1'b1;
                        state <= FETCH;
                        if (plane != PW'(BITS - 1)) begin
                            plane <= plane + PW'(1);
                        end else begin
                            plane <= '0;
                            if (row_cnt != RW'(HALF - 1)) begin
                                row_cnt <= row_cnt + RW'(1);
                            end else begin
                                row_cnt     <= '0;
                                frame_start <= 1'b1;
                                if (swap_pend || host.swap_req) begin
                                    front         <= ~front;
                                    swap_pend     <= 1'b0;
                                    host.swap_ack <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        delay_cnt <= delay_cnt - 32'd1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Scoreboard bench for hub75_bcm_driver on a 4x4 panel with two bit-planes;
// each frame's expected shift data, latch rows and display lengths are queued at frame start.
`timescale 1ns/1ps
module tb_hub75_bcm_driver;
    localparam int COLS      = 4;
    localparam int ROWS      = 4;
    localparam int BITS      = 2;
    localparam int BLANK_CYC = 2;
    localparam int LATCH_CYC = 1;
    localparam int BASE_CYC  = 4;
    localparam int NPIX      = ROWS * COLS;
    localparam int FRAME_CYC = (ROWS / 2) * (BITS * (3 * COLS + BLANK_CYC + LATCH_CYC)
                                             + BASE_CYC * ((1 << BITS) - 1));

    logic       clk;
    logic       reset_n;
    logic       frame_start;
    logic [2:0] rgb_a;
    logic [2:0] rgb_b;
    logic [0:0] row_address;
    logic       outclk;
    logic       latch;
    logic       eo;

    hub75_bcm_driver_if #(.ADR_W(4), .DATA_W(6)) host_if ();

    hub75_bcm_driver #(
        .COLS(COLS), .ROWS(ROWS), .BITS(BITS),
        .BLANK_CYC(BLANK_CYC), .LATCH_CYC(LATCH_CYC), .BASE_CYC(BASE_CYC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .host(host_if),
        .frame_start(frame_start),
        .rgb_a(rgb_a),
        .rgb_b(rgb_b),
        .row_address(row_address),
        .outclk(outclk),
        .latch(latch),
        .eo(eo)
    );

    int         tests_run = 0;
    int         failures  = 0;
    int         cyc       = 0;
    logic [5:0] model_mem [2][NPIX];
    bit         model_front = 0;
    bit         model_pend  = 0;
    bit         mon_en      = 0;
    bit         have_prev   = 0;
    int         prev_cyc    = 0;
    logic [5:0] exp_q [$];
    int         row_q [$];
    int         disp_q [$];
    int         oc_cnt = 0;
    int         eo_run = 0;
    logic       latch_d = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, actual, expected, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every shift pulse, latch and display window.
    always @(negedge clk) begin
        if (mon_en && outclk) begin
            if (exp_q.size() == 0) checkOutput("shift_extra", 1, 0);
            else checkOutput("shift_rgb", {rgb_a, rgb_b}, exp_q.pop_front());
        end
        if (latch && !latch_d) begin
            if (mon_en) begin
                checkOutput("outclk_per_row", oc_cnt, COLS);
                if (row_q.size() == 0) checkOutput("latch_extra", 1, 0);
                else checkOutput("row_address", row_address, row_q.pop_front());
            end
            oc_cnt = 0;
        end else if (outclk) begin
            oc_cnt++;
        end
        if (!eo) begin
            eo_run++;
        end else begin
            if (eo_run != 0 && mon_en) begin
                if (disp_q.size() == 0) checkOutput("display_extra", 1, 0);
                else checkOutput("eo_low_cycles", eo_run, disp_q.pop_front());
            end
            eo_run = 0;
        end
        latch_d = latch;
    end

    task automatic pushFrame();
        logic [5:0] a;
        logic [5:0] b;
        for (int r = 0; r < ROWS / 2; r++) begin
            for (int p = 0; p < BITS; p++) begin
                for (int c = 0; c < COLS; c++) begin
                    a = model_mem[model_front][r * COLS + c];
                    b = model_mem[model_front][(r + ROWS / 2) * COLS + c];
                    exp_q.push_back({a[2*BITS+p], a[BITS+p], a[p], b[2*BITS+p], b[BITS+p], b[p]});
                end
                row_q.push_back(r);
                disp_q.push_back(BASE_CYC << p);
            end
        end
    endtask

    // Called on the negedge where frame_start is visible; the #1 lets the monitor finish that edge first.
    task automatic frameBoundary(input bit next_mon);
        checkOutput("swap_ack", host_if.swap_ack, model_pend);
        if (have_prev) checkOutput("frame_len", cyc - prev_cyc, FRAME_CYC);
        have_prev = 1;
        prev_cyc  = cyc;
        #1;
        if (model_pend) begin
            model_front = !model_front;
            model_pend  = 0;
        end
        if (mon_en) begin
            checkOutput("shifts_left", exp_q.size(), 0);
            checkOutput("latches_left", row_q.size(), 0);
            checkOutput("displays_left", disp_q.size(), 0);
        end
        mon_en = next_mon;
        if (next_mon) pushFrame();
    endtask

    task automatic waitFrame(input bit next_mon);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 4 * FRAME_CYC);
        if (!frame_start) checkOutput("frame_start_timeout", 0, 1);
        frameBoundary(next_mon);
    endtask

    task automatic applyStimulus(input logic [3:0] adr, input logic [5:0] data);
        @(negedge clk);
        host_if.we     = 1'b1;
        host_if.adr_in = adr;
        host_if.rgb_in = data;
        model_mem[!model_front][adr] = data;
        @(negedge clk);
        host_if.we = 1'b0;
    endtask

    task automatic pulseSwap();
        @(negedge clk);
        host_if.swap_req = 1'b1;
        model_pend = 1;
        @(negedge clk);
        host_if.swap_req = 1'b0;
    endtask

    task automatic fillBack(input bit with_pattern);
        for (int i = 0; i < NPIX; i++) begin
            if (with_pattern && i == 0) applyStimulus(4'(i), 6'b110000);
            else if (with_pattern && i == 9) applyStimulus(4'(i), 6'b000100);
            else applyStimulus(4'(i), 6'($urandom_range(0, 63)));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset_n          = 1'b1;
        host_if.we       = 1'b0;
        host_if.adr_in   = '0;
        host_if.rgb_in   = '0;
        host_if.swap_req = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        checkOutput("rst_eo", eo, 1);
        checkOutput("rst_latch", latch, 0);
        checkOutput("rst_outclk", outclk, 0);
        checkOutput("rst_rgb", {rgb_a, rgb_b}, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_swap_ack", host_if.swap_ack, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("frame_start_after_release", frame_start, 1);
        frameBoundary(0);

        // Frame 1: load back bank 1 with the reference pattern, request swap mid-frame.
        fillBack(1);
        pulseSwap();
        waitFrame(1);

        // Frame 2: shows bank 1; rewrite bank 0 during the scan, two requests give one swap.
        fillBack(0);
        pulseSwap();
        pulseSwap();
        waitFrame(1);

        // Frame 3: shows bank 0; writes to bank 1 stay invisible, no swap follows.
        fillBack(0);
        waitFrame(1);

        // Frame 4: request and a write both land exactly in the frame-end cycle.
        repeat (FRAME_CYC - 1) @(negedge clk);
        host_if.swap_req = 1'b1;
        model_pend = 1;
        host_if.we     = 1'b1;
        host_if.adr_in = 4'd5;
        host_if.rgb_in = 6'b011011;
        model_mem[!model_front][5] = 6'b011011;
        @(negedge clk);
        host_if.swap_req = 1'b0;
        host_if.we       = 1'b0;
        checkOutput("frame_start_at_end", frame_start, 1);
        frameBoundary(1);

        // Frame 5 shows bank 1 with the swap-cycle write; frame 6 is used for the reset test.
        waitFrame(0);
        pulseSwap();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(eo == 1'b0 && row_address == 1'b1) && n < 2 * FRAME_CYC);
        checkOutput("reach_row1_display", {31'd0, (eo == 1'b0 && row_address == 1'b1)}, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_eo", eo, 1);
        checkOutput("midrst_latch", latch, 0);
        checkOutput("midrst_outclk", outclk, 0);
        checkOutput("midrst_rgb", {rgb_a, rgb_b}, 0);
        checkOutput("midrst_row_address", row_address, 0);
        checkOutput("midrst_frame_start", frame_start, 0);
        checkOutput("midrst_swap_ack", host_if.swap_ack, 0);
        model_front = 0;
        model_pend  = 0;
        have_prev   = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("frame_start_after_midrst", frame_start, 1);
        frameBoundary(1);
        waitFrame(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
